// File: rtl/trivium_pkg.sv
// Trivium constants, tap positions, FSM encoding and a bit-serial
// reference step/load model for the W-bit-per-clock keystream core.
package trivium_pkg;

  localparam int KEY_W          = 80;
  localparam int IV_W           = 80;
  localparam int STATE_W        = 288;
  localparam int WARMUP_DEFAULT = 1152;

  // Register boundaries in 1-based Trivium numbering.
  localparam int R1_END = 93;
  localparam int R2_END = 177;

  // Tap positions, 1-based.
  localparam int T1A = 66;
  localparam int T1B = 93;
  localparam int A_N0 = 91;
  localparam int A_N1 = 92;
  localparam int A_X  = 171;
  localparam int T2A = 162;
  localparam int T2B = 177;
  localparam int B_N0 = 175;
  localparam int B_N1 = 176;
  localparam int B_X  = 264;
  localparam int T3A = 243;
  localparam int T3B = 288;
  localparam int C_N0 = 286;
  localparam int C_N1 = 287;
  localparam int C_X  = 69;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } state_e;

  typedef struct packed {
    logic [STATE_W-1:0] s;
    logic               z;
  } step_t;

  function automatic logic [STATE_W-1:0] trivium_load(
    input logic [KEY_W-1:0] key,
    input logic [IV_W-1:0]  iv
  );
    logic [STATE_W-1:0] st;
    st = '0;
    for (int i = 0; i < KEY_W; i++)
      st[i] = key[i];
    for (int i = 0; i < IV_W; i++)
      st[R1_END + i] = iv[i];
    st[C_N0-1] = 1'b1;
    st[C_N1-1] = 1'b1;
    st[T3B-1]  = 1'b1;
    return st;
  endfunction

  // One step on a 1-based unpacked copy of the state.
  function automatic step_t trivium_ref_step(
    input logic [STATE_W-1:0] st
  );
    logic  s [1:STATE_W];
    logic  t1, t2, t3, a, b, c;
    step_t r;
    for (int i = 1; i <= STATE_W; i++)
      s[i] = st[i-1];
    t1 = s[T1A] ^ s[T1B];
    t2 = s[T2A] ^ s[T2B];
    t3 = s[T3A] ^ s[T3B];
    a  = t1 ^ (s[A_N0] & s[A_N1]) ^ s[A_X];
    b  = t2 ^ (s[B_N0] & s[B_N1]) ^ s[B_X];
    c  = t3 ^ (s[C_N0] & s[C_N1]) ^ s[C_X];
    r.z = t1 ^ t2 ^ t3;
    for (int i = STATE_W; i >= 2; i--)
      s[i] = s[i-1];
    s[1]          = c;
    s[R1_END + 1] = a;
    s[R2_END + 1] = b;
    for (int i = 1; i <= STATE_W; i++)
      r.s[i-1] = s[i];
    return r;
  endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium step.
// Ports: state_in (s1 at bit 0), state_out, z keystream bit.
import trivium_pkg::*;

module trivium_round (
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               z
);

  logic t1, t2, t3;
  logic a, b, c;

  assign t1 = state_in[T1A-1] ^ state_in[T1B-1];
  assign t2 = state_in[T2A-1] ^ state_in[T2B-1];
  assign t3 = state_in[T3A-1] ^ state_in[T3B-1];

  assign a = t1
           ^ (state_in[A_N0-1] & state_in[A_N1-1])
           ^ state_in[A_X-1];
  assign b = t2
           ^ (state_in[B_N0-1] & state_in[B_N1-1])
           ^ state_in[B_X-1];
  assign c = t3
           ^ (state_in[C_N0-1] & state_in[C_N1-1])
           ^ state_in[C_X-1];

  assign z = t1 ^ t2 ^ t3;

  // Each register shifts up by one; the feedback enters at its base.
  assign state_out = {
    state_in[STATE_W-2:R2_END], b,
    state_in[R2_END-2:R1_END],  a,
    state_in[R1_END-2:0],       c
  };

endmodule

// File: rtl/trivium_stream.sv
// W-bit-per-clock Trivium keystream source with multi-cycle warm-up.
// Ports: clk, rst_n, start/key/iv load, busy, ks_valid/ks_ready/ks_data.
import trivium_pkg::*;

module trivium_stream #(
  parameter int W            = 8,
  parameter int WARMUP_STEPS = WARMUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  output logic             busy,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [W-1:0]     ks_data
);

  localparam int CNT_MAX = WARMUP_STEPS / W;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 ||
        W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $error("trivium_stream: W must be 1,2,4,8,16,32 or 64");
  end

  if ((WARMUP_STEPS % W) != 0) begin : g_bad_warm
    $error("trivium_stream: WARMUP_STEPS must be a multiple of W");
  end

  logic [STATE_W-1:0] s;
  logic [STATE_W-1:0] load_s;
  logic [CW-1:0]      warm_cnt;
  state_e             state;

  logic [STATE_W-1:0] chain [0:W];
  logic [W-1:0]       zv;

  assign chain[0] = s;

  for (genvar j = 0; j < W; j++) begin : g_chain
    trivium_round u_round (
      .state_in  (chain[j]),
      .state_out (chain[j+1]),
      .z         (zv[j])
    );
  end

  always_comb begin
    load_s = '0;
    load_s[KEY_W-1:0]      = key;
    load_s[R1_END +: IV_W] = iv;
    load_s[STATE_W-1 -: 3] = 3'b111;
  end

  // start wins over any advance, including a RUN handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      warm_cnt <= '0;
      state    <= IDLE;
    end else if (start) begin
      s        <= load_s;
      warm_cnt <= '0;
      state    <= WARM;
    end else begin
      unique case (state)
        WARM: begin
          s <= chain[W];
          if (warm_cnt == CNT_LAST) begin
            warm_cnt <= '0;
            state    <= RUN;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        RUN: begin
          if (ks_ready)
            s <= chain[W];
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == WARM);
  assign ks_valid = (state == RUN);
  // All-zero state yields all-zero z, so ks_data is 0 out of reset.
  assign ks_data  = zv;

endmodule

// File: tb/tb_trivium_stream.sv
// Scoreboarded bench for trivium_stream at W = 8, 1 and 64.
// Expected keystream comes from the package bit-serial model.
import trivium_pkg::*;

module tb_trivium_stream;

  localparam logic [79:0] KA = 80'h0123456789ABCDEF0123;
  localparam logic [79:0] IA = 80'hFEDCBA9876543210FEDC;
  localparam logic [79:0] KB = 80'h13579BDF02468ACE1122;
  localparam logic [79:0] IB = 80'h0F1E2D3C4B5A69788796;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ks_ready;
  logic [79:0] key;
  logic [79:0] iv;

  logic        busy8, v8;
  logic [7:0]  d8;
  logic        busy1, v1;
  logic [0:0]  d1;
  logic        busy64, v64;
  logic [63:0] d64;

  int          sel;
  logic        kv, kb;
  logic [63:0] kd;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          exp_q [$];
  logic [63:0] obs_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  trivium_stream #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .key(key), .iv(iv), .busy(busy8),
    .ks_valid(v8), .ks_ready(ks_ready), .ks_data(d8)
  );

  trivium_stream #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .key(key), .iv(iv), .busy(busy1),
    .ks_valid(v1), .ks_ready(ks_ready), .ks_data(d1)
  );

  trivium_stream #(.W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .key(key), .iv(iv), .busy(busy64),
    .ks_valid(v64), .ks_ready(ks_ready), .ks_data(d64)
  );

  always_comb begin
    kv = v8;
    kb = busy8;
    kd = {56'b0, d8};
    case (sel)
      1: begin
        kv = v1;
        kb = busy1;
        kd = {63'b0, d1};
      end
      2: begin
        kv = v64;
        kb = busy64;
        kd = d64;
      end
      default: ;
    endcase
  end

  function automatic int width();
    case (sel)
      1:       return 1;
      2:       return 64;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] pop_beat();
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < width(); j++) begin
      if (exp_q.size() > 0) r[j] = exp_q.pop_front();
      else                  r[j] = 1'bx;
    end
    return r;
  endfunction

  task automatic push_golden(input logic [79:0] k,
                             input logic [79:0] v,
                             input int nbits);
    logic [STATE_W-1:0] st;
    step_t r;
    st = trivium_load(k, v);
    repeat (WARMUP_DEFAULT) begin
      r  = trivium_ref_step(st);
      st = r.s;
    end
    repeat (nbits) begin
      r = trivium_ref_step(st);
      exp_q.push_back(r.z);
      st = r.s;
    end
  endtask

  task automatic do_start(input logic [79:0] k,
                          input logic [79:0] v,
                          input int ncyc);
    @(negedge clk);
    key   = k;
    iv    = v;
    start = 1'b1;
    repeat (ncyc) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int drop);
    n    = 0;
    drop = 0;
    while (!kv && n < 5000) begin
      if (!kb) drop++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input int nbeats, input int pct,
                       output int got, output int unstable);
    logic [63:0] held;
    bit          held_v;
    int          cyc;
    got      = 0;
    unstable = 0;
    held_v   = 1'b0;
    held     = '0;
    cyc      = 0;
    while (got < nbeats && cyc < 20000) begin
      if (kv) begin
        if (held_v && kd !== held) unstable++;
        if (int'($urandom_range(0, 99)) < pct) begin
          ks_ready = 1'b0;
          held_v   = 1'b1;
          held     = kd;
        end else begin
          ks_ready = 1'b1;
          held_v   = 1'b0;
          obs_q.push_back(kd);
          got++;
        end
      end else begin
        ks_ready = 1'b0;
        held_v   = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    ks_ready = 1'b0;
  endtask

  task automatic test_reset();
    sel      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    ks_ready = 1'b0;
    key      = '0;
    iv       = '0;
    #1;
    n_cmp++;
    if (kv !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 0", kv);
    end
    n_cmp++;
    if (kb !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b want 0", kb);
    end
    n_cmp++;
    if (kd !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", kd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_warmup();
    int n, drop;
    int exp_n [2];
    exp_n[0] = 144;
    exp_n[1] = 1152;
    for (int i = 0; i < 2; i++) begin
      sel = i;
      do_start('0, '0, 1);
      wait_valid(n, drop);
      n_cmp++;
      if (n !== exp_n[i]) begin
        n_bad++;
        $display("FAIL warmup_latency w=%0d: got %0d want %0d",
                 width(), n, exp_n[i]);
      end
      n_cmp++;
      if (drop !== 0) begin
        n_bad++;
        $display("FAIL warmup_busy w=%0d: low %0d cycles want 0",
                 width(), drop);
      end
    end
  endtask

  task automatic test_golden();
    int n, drop, got, unst, nb;
    logic [63:0] o, e;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? 0 : 2;
      nb  = 1024 / width();
      exp_q.delete();
      obs_q.delete();
      do_start(KA, IA, 1);
      push_golden(KA, IA, 1024);
      wait_valid(n, drop);
      n_cmp++;
      if (n !== 1152 / width()) begin
        n_bad++;
        $display("FAIL golden_latency w=%0d: got %0d want %0d",
                 width(), n, 1152 / width());
      end
      drain(nb, 0, got, unst);
      n_cmp++;
      if (got !== nb) begin
        n_bad++;
        $display("FAIL golden_count w=%0d: got %0d want %0d",
                 width(), got, nb);
      end
      for (int b = 0; b < got; b++) begin
        o = obs_q.pop_front();
        e = pop_beat();
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL golden w=%0d beat %0d: got %h want %h",
                   width(), b, o, e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n, drop, got, unst;
    logic [63:0] o, e;
    sel = 0;
    exp_q.delete();
    obs_q.delete();
    do_start(KA, IA, 1);
    push_golden(KA, IA, 512);
    wait_valid(n, drop);
    drain(64, 30, got, unst);
    n_cmp++;
    if (unst !== 0) begin
      n_bad++;
      $display("FAIL bp_stable: %0d changes while stalled want 0",
               unst);
    end
    n_cmp++;
    if (got !== 64) begin
      n_bad++;
      $display("FAIL bp_count: got %0d want 64", got);
    end
    for (int b = 0; b < got; b++) begin
      o = obs_q.pop_front();
      e = pop_beat();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL bp beat %0d: got %h want %h", b, o, e);
      end
    end
  endtask

  task automatic test_rekey_stream();
    int n, drop, got, unst;
    logic [63:0] o, e;
    sel = 0;
    exp_q.delete();
    obs_q.delete();
    do_start(KA, IA, 1);
    push_golden(KA, IA, 48);
    wait_valid(n, drop);
    drain(5, 0, got, unst);
    // Beat 5 of key A is handed over on the same edge as start.
    obs_q.push_back(kd);
    n_cmp++;
    if (kv !== 1'b1) begin
      n_bad++;
      $display("FAIL rk_beat5_valid: got %b want 1", kv);
    end
    key      = KB;
    iv       = IB;
    start    = 1'b1;
    ks_ready = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ks_ready = 1'b0;
    for (int b = 0; b < 6; b++) begin
      o = obs_q.pop_front();
      e = pop_beat();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rk_a beat %0d: got %h want %h", b, o, e);
      end
    end
    exp_q.delete();
    push_golden(KB, IB, 128);
    wait_valid(n, drop);
    n_cmp++;
    if (n !== 144 || drop !== 0) begin
      n_bad++;
      $display("FAIL rk_latency: got %0d (busy low %0d) want 144",
               n, drop);
    end
    drain(16, 0, got, unst);
    for (int b = 0; b < got; b++) begin
      o = obs_q.pop_front();
      e = pop_beat();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rk_b beat %0d: got %h want %h", b, o, e);
      end
    end
  endtask

  task automatic test_rekey_warm();
    int n, drop, got, unst;
    logic [63:0] o, e;
    sel = 0;
    exp_q.delete();
    obs_q.delete();
    do_start(KA, IA, 1);
    repeat (70) @(negedge clk);
    n_cmp++;
    if (kb !== 1'b1) begin
      n_bad++;
      $display("FAIL rkw_busy: got %b want 1", kb);
    end
    do_start(KB, IB, 1);
    push_golden(KB, IB, 128);
    wait_valid(n, drop);
    n_cmp++;
    if (n !== 144 || drop !== 0) begin
      n_bad++;
      $display("FAIL rkw_latency: got %0d (busy low %0d) want 144",
               n, drop);
    end
    drain(16, 0, got, unst);
    for (int b = 0; b < got; b++) begin
      o = obs_q.pop_front();
      e = pop_beat();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rkw beat %0d: got %h want %h", b, o, e);
      end
    end
  endtask

  task automatic test_multi_start();
    int n, drop, got, unst;
    logic [63:0] o, e;
    sel = 0;
    exp_q.delete();
    obs_q.delete();
    do_start(KB, IB, 3);
    push_golden(KB, IB, 64);
    wait_valid(n, drop);
    n_cmp++;
    if (n !== 144) begin
      n_bad++;
      $display("FAIL multi_latency: got %0d want 144", n);
    end
    drain(8, 0, got, unst);
    for (int b = 0; b < got; b++) begin
      o = obs_q.pop_front();
      e = pop_beat();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL multi beat %0d: got %h want %h", b, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    sel = 0;
    n_cmp++;
    if (kv !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_pre_valid: got %b want 1", kv);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (kv !== 1'b0 || kb !== 1'b0 || kd !== 64'h0) begin
      n_bad++;
      $display("FAIL ar_immediate: v=%b b=%b d=%h want 0/0/0",
               kv, kb, kd);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    ks_ready = 1'b1;
    repeat (20) @(negedge clk);
    ks_ready = 1'b0;
    n_cmp++;
    if (kv !== 1'b0 || kb !== 1'b0 || kd !== 64'h0) begin
      n_bad++;
      $display("FAIL ar_hold: v=%b b=%b d=%h want 0/0/0",
               kv, kb, kd);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_golden();
    test_backpressure();
    test_rekey_stream();
    test_rekey_warm();
    test_multi_start();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
